// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver for an HH:MM clock: one shared active-low
// segment bus, one-hot active-low anodes, field blink, colon blink and leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 100,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hours_tenth,
  input  logic [3:0] hours_units,
  input  logic [2:0] minutes_tenth,
  input  logic [3:0] minutes_units,
  input  logic       blink_hours,
  input  logic       blink_minutes,
  input  logic       colon_en,
  output logic [3:0] anode,
  output logic [6:0] segments,
  output logic       dp,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [1:0]    snap_ht_q, snap_ht_d;
  logic [3:0]    snap_hu_q, snap_hu_d;
  logic [2:0]    snap_mt_q, snap_mt_d;
  logic [3:0]    snap_mu_q, snap_mu_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  logic          slot_tick, wrap, bad, blank;
  logic [3:0]    digit;

  function automatic logic [6:0] decode(input logic [3:0] d, input logic out_of_range);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return out_of_range ? 7'h3F : s;
  endfunction

  always_comb begin
    slot_tick    = (pre_q == PRE_MAX);
    wrap         = slot_tick && (idx_q == 2'd3);
    pre_d        = slot_tick ? '0 : pre_q + 1'b1;
    idx_d        = slot_tick ? idx_q + 2'd1 : idx_q;
    frame_tick_d = wrap;

    snap_ht_d = snap_ht_q;
    snap_hu_d = snap_hu_q;
    snap_mt_d = snap_mt_q;
    snap_mu_d = snap_mu_q;
    if (wrap) begin
      snap_ht_d = hours_tenth;
      snap_hu_d = hours_units;
      snap_mt_d = minutes_tenth;
      snap_mu_d = minutes_units;
    end

    // Blink counter advances once per frame, one cycle after the frame starts
    blink_d = blink_q;
    phase_d = phase_q;
    if (frame_tick_q) begin
      if (blink_q == BLINK_MAX) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end

    // Slot 0 decodes the live inputs because the snapshot is loaded on this same edge
    case (idx_d)
      2'd0:    begin digit = minutes_units;      bad = (minutes_units > 4'd9); end
      2'd1:    begin digit = {1'b0, snap_mt_q};  bad = (snap_mt_q > 3'd5);     end
      2'd2:    begin digit = snap_hu_q;          bad = (snap_hu_q > 4'd9);     end
      default: begin digit = {2'b00, snap_ht_q}; bad = (snap_ht_q > 2'd2);     end
    endcase

    blank = phase_q && (idx_d[1] ? blink_hours : blink_minutes);
    if (LZ_BLANK && (idx_d == 2'd3) && (snap_ht_q == 2'd0)) blank = 1'b1;

    anode_d = anode_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    if (slot_tick) begin
      anode_d = blank ? 4'hF : ~(4'b0001 << idx_d);
      seg_d   = decode(digit, bad);
      dp_d    = ~((idx_d == 2'd2) && colon_en && !phase_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q        <= '0;
      idx_q        <= 2'd3;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      snap_ht_q    <= '0;
      snap_hu_q    <= '0;
      snap_mt_q    <= '0;
      snap_mu_q    <= '0;
      anode_q      <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      snap_ht_q    <= snap_ht_d;
      snap_hu_q    <= snap_hu_d;
      snap_mt_q    <= snap_mt_d;
      snap_mu_q    <= snap_mu_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign anode      = anode_q;
  assign segments   = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
